// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, memory-wait stalls, branch flushes, halt/error freeze.
// Optional stall-cycle statistics counter is built only when HAZARD_STATS_EN is defined.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  regSelRs_D,
  input  logic [2:0]  regSelRt_D,
  input  logic        rsUsed_D,
  input  logic        rtUsed_D,
  input  logic        memRead_X,
  input  logic        writeEn_X,
  input  logic [2:0]  writeRegSel_X,
  input  logic        branchTaken_X,
  input  logic        memStall_M,
  input  logic        memDone_M,
  input  logic        halt_M,
  input  logic        err,
  output logic        pcHold,
  output logic        stallFD,
  output logic        stallDX,
  output logic        stallXM,
  output logic        flushFD,
  output logic        flushDX,
  output logic        err_out,
  output logic [15:0] stallCycles
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALTED} state_e;

  state_e state_q, state_d;
  logic   pendFlush_q, pendFlush_d;
  logic   err_q, err_d;
  logic   loadUse;

  assign loadUse = memRead_X & writeEn_X &
                   ((rsUsed_D & (regSelRs_D == writeRegSel_X)) |
                    (rtUsed_D & (regSelRt_D == writeRegSel_X)));

  always_comb begin
    state_d     = state_q;
    pendFlush_d = pendFlush_q;
    err_d       = err_q;
    pcHold      = 1'b0;
    stallFD     = 1'b0;
    stallDX     = 1'b0;
    stallXM     = 1'b0;
    flushFD     = 1'b0;
    flushDX     = 1'b0;
    if (rst) begin
      state_d     = RUN;
      pendFlush_d = 1'b0;
      err_d       = 1'b0;
    end else begin
      if (err) err_d = 1'b1;
      if (halt_M || err || state_q == HALTED) begin
        {pcHold, stallFD, stallDX, stallXM} = 4'b1111;
        state_d = HALTED;
      end else if (state_q == MEMWAIT) begin
        if (!memDone_M) {pcHold, stallFD, stallDX, stallXM} = 4'b1111;
        else            state_d = RUN;
      end else if (memStall_M) begin
        {pcHold, stallFD, stallDX, stallXM} = 4'b1111;
        state_d = MEMWAIT;
      end else if (branchTaken_X || pendFlush_q) begin
        // A load-use request in the same cycle is dropped: the flush kills the consumer anyway.
        {flushFD, flushDX} = 2'b11;
        pendFlush_d = 1'b0;
      end else if (loadUse) begin
        {pcHold, stallFD, flushDX} = 3'b111;
      end
      // A branch seen while the pipe is frozen must still redirect once it resumes.
      if (branchTaken_X && (stallFD || stallDX || stallXM)) pendFlush_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    pendFlush_q <= pendFlush_d;
    err_q       <= err_d;
  end

  assign err_out = err_q;

`ifdef HAZARD_STATS_EN
  logic [15:0] stallCnt_q, stallCnt_d;

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (rst)                                  stallCnt_d = 16'h0000;
    else if (stallFD && stallCnt_q != 16'hFFFF) stallCnt_d = stallCnt_q + 16'h0001;
  end

  always_ff @(posedge clk) begin
    stallCnt_q <= stallCnt_d;
  end

  assign stallCycles = stallCnt_q;
`else
  assign stallCycles = 16'h0000;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port: regSelRs_D  input  3  Rs source register of the instruction in decode.
REQ-004 SHALL have port: regSelRt_D  input  3  Rt source register of the instruction in decode.
REQ-005 SHALL have port: rsUsed_D, rtUsed_D  input  1 each  decode instruction reads Rs / Rt.
REQ-006 SHALL have port: memRead_X  input  1  instruction in execute is a load.
REQ-007 SHALL have port: writeEn_X  input  1  instruction in execute writes the register file.
REQ-008 SHALL have port: writeRegSel_X  input  3  destination register of the instruction in execute.
REQ-009 SHALL have port: branchTaken_X  input  1  control transfer resolved taken in execute.
REQ-010 SHALL have port: memStall_M  input  1  memory stage busy (cache miss) request.
REQ-011 SHALL have port: memDone_M  input  1  memory access complete; valid in MEMWAIT only.
REQ-012 SHALL have port: halt_M, err  input  1 each  halt reached memory / error raised by any stage.
REQ-013 SHALL have port: pcHold  output  1  hold the PC.
REQ-014 SHALL have port: stallFD, stallDX, stallXM  output  1 each  hold the F/D, D/X, X/M pipeline registers.
REQ-015 SHALL have port: flushFD, flushDX  output  1 each  replace F/D, D/X contents with NOP.
REQ-016 SHALL have port: err_out  output  1  sticky error flag.
REQ-017 SHALL have port: stallCycles  output  16  stall-cycle count (see Configuration).

Function
REQ-018 SHALL implement FSM states RUN, MEMWAIT, HALTED; the encoding is free.
REQ-019 SHALL drive all control outputs combinationally from the current state, pendingFlush and the inputs, so they take effect on the edge that closes the current cycle.
REQ-020 SHALL, in RUN with memStall_M=1: assert pcHold, stallFD, stallDX and stallXM; flushes=0; next state MEMWAIT.
REQ-021 SHALL, in MEMWAIT with memDone_M=0: assert pcHold, stallFD, stallDX and stallXM; flushes=0; stay in MEMWAIT.
REQ-022 SHALL, in MEMWAIT with memDone_M=1: deassert all stalls that cycle; next state RUN.
REQ-023 SHALL set the pendingFlush flag whenever branchTaken_X=1 during a cycle in which stalls are asserted.
REQ-024 SHALL, on the first RUN cycle with pendingFlush=1: assert flushFD and flushDX; clear pendingFlush.
REQ-025 SHALL, in RUN with memStall_M=0 and branchTaken_X=1: assert flushFD and flushDX; pcHold=0.
REQ-026 SHALL detect a load-use hazard as memRead_X & writeEn_X & ((rsUsed_D & regSelRs_D==writeRegSel_X) | (rtUsed_D & regSelRt_D==writeRegSel_X)).
REQ-027 SHALL, on a load-use hazard in RUN with no memStall_M and no branch: assert pcHold, stallFD and flushDX (one bubble) for exactly that cycle.
REQ-028 SHALL apply priority memStall_M > branch flush (taken or pending) > load-use; a load-use request coincident with a flush SHALL be dropped.
REQ-029 SHALL, on halt_M=1 or err=1 in any state: enter HALTED; pcHold and all stalls=1 and flushes=0 from that cycle on.
REQ-030 SHALL remain in HALTED until rst.
REQ-031 SHALL set err_out on the edge after err=1 and hold it until rst.
REQ-032 SHALL, with no hazard in RUN: all outputs 0 except err_out and stallCycles.

Reset
REQ-033 SHALL, on rst: state=RUN, pendingFlush=0, err_out=0, stallCycles=0.
REQ-034 SHALL, during reset cycles: pcHold, all stalls and all flushes=0.
REQ-035 SHALL, on rst asserted mid-MEMWAIT or in HALTED: return to RUN on the next edge, discarding any pending flush.

Configuration
REQ-036 SHALL, with macro HAZARD_STATS_EN defined: count cycles with stallFD=1 in stallCycles, saturating at 16'hFFFF.
REQ-037 SHALL, with HAZARD_STATS_EN undefined: tie stallCycles to 16'h0000 and build no counter.

Verification
REQ-038 SHALL cover: load r3 in X (writeRegSel_X=3), decode rsUsed_D=1 with regSelRs_D=3 -> one cycle with pcHold=stallFD=flushDX=1, then all 0.
REQ-039 SHALL cover: memStall_M=1 for 1 cycle, memDone_M=1 after 4 MEMWAIT cycles -> stalls=1 for 5 cycles, 0 on the memDone cycle.
REQ-040 SHALL cover: branchTaken_X=1 during MEMWAIT -> flushFD=flushDX=1 on the first RUN cycle only.
REQ-041 SHALL cover: branchTaken_X=1 and load-use hazard in the same RUN cycle -> flushFD=flushDX=1, stallFD=0.
REQ-042 SHALL cover: err=1 for one cycle -> err_out=1 and all stalls=1 persistently; rst -> all outputs 0.
REQ-043 SHALL cover: with HAZARD_STATS_EN defined, 3 load-use bubbles -> stallCycles=3; undefined -> stallCycles=0.
